// File: rtl/imem_load_arbiter.sv
// Arbitrates instruction memory between a boot loader (IDLE/LOAD) and CPU fetch (RUN).
// Combinational write/fetch path; the loader is throttled by ld_ready and the CPU is held by cpu_stall.
module imem_load_arbiter #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_start,
    input  logic [AW:0]   ld_count,
    input  logic          ld_valid,
    input  logic [31:0]   ld_data,
    output logic          ld_ready,
    input  logic          run_req,
    input  logic          fetch_req,
    input  logic [31:0]   fetch_addr,
    output logic          fetch_gnt,
    output logic          cpu_stall,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          load_done,
    output logic          misalign
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    state_t      state, state_nxt;
    logic [AW:0] wr_ptr;
    logic [AW:0] target;
    logic [AW:0] count_clamped;
    logic        load_acc;
    logic        last_wr;
    logic        misalign_set;
    logic        unused_fetch_bits;

    // Upper address bits are dropped so fetches wrap modulo DEPTH.
    assign unused_fetch_bits = ^{fetch_addr[31:AW+2]};

    assign count_clamped = (ld_count > DEPTH_W) ? DEPTH_W : ld_count;
    assign load_acc      = load_start && (state != LOAD);
    assign last_wr       = (state == LOAD) && ld_valid && (wr_ptr == target - 1'b1);
    assign misalign_set  = (state == RUN) && fetch_req && (fetch_addr[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ld_ready  = 1'b0;
        cpu_stall = 1'b1;
        fetch_gnt = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = wr_ptr[AW-1:0];
        mem_wdata = ld_data;
        case (state)
            IDLE: begin
                if (load_start) begin
                    state_nxt = (count_clamped == '0) ? RUN : LOAD;
                end else if (run_req) begin
                    state_nxt = RUN;
                end
            end
            LOAD: begin
                ld_ready = 1'b1;
                mem_we   = ld_valid;
                if (last_wr) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                cpu_stall = 1'b0;
                fetch_gnt = fetch_req;
                mem_addr  = fetch_addr[AW+1:2];
                if (load_start) begin
                    state_nxt = (count_clamped == '0) ? RUN : LOAD;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A new load clears the sticky misalign flag even if the same cycle fetches misaligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            target    <= '0;
            misalign  <= 1'b0;
            load_done <= 1'b0;
        end else begin
            load_done <= (load_acc && (count_clamped == '0)) || last_wr;
            if (load_acc) begin
                wr_ptr   <= '0;
                target   <= count_clamped;
                misalign <= 1'b0;
            end else begin
                if (mem_we) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (misalign_set) begin
                    misalign <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Directed bench for imem_load_arbiter: loading, gaps, fetch/misalign, clamping, reset abort, priority.
module tb_imem_load_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic [10:0] ld_count;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        run_req;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_gnt;
    logic        cpu_stall;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        load_done;
    logic        misalign;

    int n_checks = 0;
    int n_fail   = 0;

    imem_load_arbiter #(.DEPTH(1024), .AW(10)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .ld_count(ld_count),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .run_req(run_req), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_gnt(fetch_gnt), .cpu_stall(cpu_stall), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .load_done(load_done),
        .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        load_start = 1'b0; ld_count = '0; ld_valid = 1'b0; ld_data = '0;
        run_req = 1'b0; fetch_req = 1'b0; fetch_addr = '0;
    endtask

    task automatic do_reset;
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst = 1'b1;
        fetch_req = 1'b1;
        tick();
        tick();
        n_checks++; if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall: got %b want 1", cpu_stall); end
        n_checks++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ld_ready); end
        n_checks++; if (fetch_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got %b want 0", fetch_gnt); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", mem_we); end
        n_checks++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", load_done); end
        n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b want 0", misalign); end
        n_checks++; if (mem_addr !== 10'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", mem_addr); end
        rst = 1'b0;
        fetch_req = 1'b0;
    endtask

    task automatic test_load4;
        do_reset();
        load_start = 1'b1; ld_count = 11'd4;
        #1;
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL load4_idle_we: got %b want 0", mem_we); end
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b1; ld_data = 32'hA0 + i;
            #1;
            n_checks++; if (mem_we !== 1'b1 || ld_ready !== 1'b1 || cpu_stall !== 1'b1) begin n_fail++; $display("FAIL load4_we[%0d]: got we=%b rdy=%b stall=%b want 1,1,1", i, mem_we, ld_ready, cpu_stall); end
            n_checks++; if (mem_addr !== 10'(i) || mem_wdata !== 32'hA0 + i) begin n_fail++; $display("FAIL load4_addr[%0d]: got %0d/%h want %0d/%h", i, mem_addr, mem_wdata, i, 32'hA0 + i); end
            n_checks++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL load4_early_done[%0d]: got %b want 0", i, load_done); end
            tick();
        end
        ld_valid = 1'b0;
        #1;
        n_checks++; if (load_done !== 1'b1 || cpu_stall !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL load4_done: got done=%b stall=%b we=%b want 1,0,0", load_done, cpu_stall, mem_we); end
        tick();
        n_checks++; if (load_done !== 1'b0 || cpu_stall !== 1'b0) begin n_fail++; $display("FAIL load4_after: got done=%b stall=%b want 0,0", load_done, cpu_stall); end
    endtask

    task automatic test_gapped;
        logic [4:0] pat;
        int writes;
        pat = 5'b10101;
        writes = 0;
        do_reset();
        load_start = 1'b1; ld_count = 11'd3;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ld_valid = pat[i]; ld_data = 32'hB0 + i;
            #1;
            n_checks++; if (mem_we !== pat[i] || mem_addr !== 10'(writes)) begin n_fail++; $display("FAIL gapped[%0d]: got we=%b addr=%0d want %b/%0d", i, mem_we, mem_addr, pat[i], writes); end
            if (mem_we === 1'b1) writes++;
            tick();
        end
        ld_valid = 1'b0;
        #1;
        n_checks++; if (writes !== 3 || load_done !== 1'b1 || cpu_stall !== 1'b0) begin n_fail++; $display("FAIL gapped_done: got writes=%0d done=%b stall=%b want 3,1,0", writes, load_done, cpu_stall); end
    endtask

    task automatic test_fetch;
        // entered in RUN from the previous load
        fetch_req = 1'b1; fetch_addr = 32'h0000_1008;
        #1;
        n_checks++; if (fetch_gnt !== 1'b1 || mem_addr !== 10'd2 || mem_we !== 1'b0) begin n_fail++; $display("FAIL fetch_aligned: got gnt=%b addr=%0d we=%b want 1,2,0", fetch_gnt, mem_addr, mem_we); end
        tick();
        fetch_addr = 32'h0000_0006;
        #1;
        n_checks++; if (fetch_gnt !== 1'b1 || mem_addr !== 10'd1 || misalign !== 1'b0) begin n_fail++; $display("FAIL fetch_mis_cycle: got gnt=%b addr=%0d mis=%b want 1,1,0", fetch_gnt, mem_addr, misalign); end
        tick();
        fetch_addr = 32'hFFFF_100C;
        #1;
        n_checks++; if (misalign !== 1'b1) begin n_fail++; $display("FAIL fetch_mis_set: got %b want 1", misalign); end
        n_checks++; if (mem_addr !== 10'd3) begin n_fail++; $display("FAIL fetch_wrap: got %0d want 3", mem_addr); end
        tick();
        fetch_req = 1'b0;
        #1;
        n_checks++; if (misalign !== 1'b1 || fetch_gnt !== 1'b0) begin n_fail++; $display("FAIL fetch_sticky: got mis=%b gnt=%b want 1,0", misalign, fetch_gnt); end
        load_start = 1'b1; ld_count = 11'd1; fetch_req = 1'b1; fetch_addr = 32'h10;
        #1;
        n_checks++; if (fetch_gnt !== 1'b1 || mem_addr !== 10'd4) begin n_fail++; $display("FAIL run_reload_gnt: got gnt=%b addr=%0d want 1,4", fetch_gnt, mem_addr); end
        tick();
        clear_inputs();
        ld_valid = 1'b1; ld_data = 32'hC0;
        #1;
        n_checks++; if (ld_ready !== 1'b1 || cpu_stall !== 1'b1 || misalign !== 1'b0 || mem_addr !== 10'd0) begin n_fail++; $display("FAIL run_reload: got rdy=%b stall=%b mis=%b addr=%0d want 1,1,0,0", ld_ready, cpu_stall, misalign, mem_addr); end
        tick();
        ld_valid = 1'b0;
        #1;
        n_checks++; if (load_done !== 1'b1 || cpu_stall !== 1'b0) begin n_fail++; $display("FAIL run_reload_done: got done=%b stall=%b want 1,0", load_done, cpu_stall); end
    endtask

    task automatic test_zero_count;
        do_reset();
        load_start = 1'b1; ld_count = 11'd0; ld_valid = 1'b1;
        tick();
        load_start = 1'b0;
        #1;
        n_checks++; if (load_done !== 1'b1 || cpu_stall !== 1'b0 || mem_we !== 1'b0 || ld_ready !== 1'b0) begin n_fail++; $display("FAIL zero_count: got done=%b stall=%b we=%b rdy=%b want 1,0,0,0", load_done, cpu_stall, mem_we, ld_ready); end
        tick();
        n_checks++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL zero_count_pulse: got %b want 0", load_done); end
        ld_valid = 1'b0;
    endtask

    task automatic test_clamp;
        int writes;
        int last_addr;
        bit done;
        writes = 0; last_addr = -1; done = 1'b0;
        do_reset();
        load_start = 1'b1; ld_count = 11'd2000;
        tick();
        load_start = 1'b0;
        ld_valid = 1'b1;
        for (int i = 0; i < 1100 && !done; i++) begin
            ld_data = i;
            #1;
            if (load_done === 1'b1) begin
                done = 1'b1;
            end else begin
                if (mem_we === 1'b1) begin writes++; last_addr = int'(mem_addr); end
                tick();
            end
        end
        ld_valid = 1'b0;
        n_checks++; if (!done) begin n_fail++; $display("FAIL clamp_timeout: got no load_done want load_done within 1100 cycles"); end
        n_checks++; if (writes !== 1024 || last_addr !== 1023) begin n_fail++; $display("FAIL clamp_writes: got %0d writes last %0d want 1024 last 1023", writes, last_addr); end
    endtask

    task automatic test_rst_abort;
        do_reset();
        load_start = 1'b1; ld_count = 11'd5;
        tick();
        load_start = 1'b0;
        ld_valid = 1'b1;
        tick();
        tick();
        ld_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; ld_valid = 1'b1;
        #1;
        n_checks++; if (ld_ready !== 1'b0 || cpu_stall !== 1'b1 || mem_we !== 1'b0 || load_done !== 1'b0 || mem_addr !== 10'd0) begin n_fail++; $display("FAIL rst_abort: got rdy=%b stall=%b we=%b done=%b addr=%0d want 0,1,0,0,0", ld_ready, cpu_stall, mem_we, load_done, mem_addr); end
        tick();
        n_checks++; if (load_done !== 1'b0 || ld_ready !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_abort_idle: got done=%b rdy=%b we=%b want 0,0,0", load_done, ld_ready, mem_we); end
        ld_valid = 1'b0;
    endtask

    task automatic test_priority;
        do_reset();
        run_req = 1'b1; load_start = 1'b1; ld_count = 11'd2;
        tick();
        clear_inputs();
        run_req = 1'b1;
        #1;
        n_checks++; if (ld_ready !== 1'b1 || cpu_stall !== 1'b1) begin n_fail++; $display("FAIL prio_load: got rdy=%b stall=%b want 1,1", ld_ready, cpu_stall); end
        tick();
        n_checks++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL prio_runreq_ignored: got rdy=%b want 1", ld_ready); end
        do_reset();
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        #1;
        n_checks++; if (cpu_stall !== 1'b0 || ld_ready !== 1'b0 || load_done !== 1'b0) begin n_fail++; $display("FAIL prio_run: got stall=%b rdy=%b done=%b want 0,0,0", cpu_stall, ld_ready, load_done); end
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        test_reset();
        test_load4();
        test_gapped();
        test_fetch();
        test_zero_count();
        test_clamp();
        test_rst_abort();
        test_priority();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
